// File: rtl/i2s_sample_tx.sv
// Takes a ready/valid mono sample stream and serializes it to an I2S DAC, sending the same sample in both slots.
// Optional feature macro: I2S_TX_HOLD_LAST_EN repeats the previous sample on underflow instead of zero-filling it.
module i2s_sample_tx #(
  parameter int unsigned width_p      = 12,
  parameter int unsigned slot_width_p = 16,
  parameter int unsigned sclk_div_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic               enable_i,
  input  logic               valid_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               sclk_o,
  output logic               ws_o,
  output logic               sd_o,
  output logic               underflow_o
);

  localparam int unsigned div_w = (sclk_div_p > 1) ? $clog2(sclk_div_p) : 1;
  localparam int unsigned bit_w = (slot_width_p > 1) ? $clog2(slot_width_p) : 1;
  localparam int unsigned idx_w = (width_p > 1) ? $clog2(width_p) : 1;
  localparam logic [div_w-1:0] div_last = div_w'(sclk_div_p - 1);
  localparam logic [bit_w-1:0] bit_last = bit_w'(slot_width_p - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LEFT,
    ST_RIGHT
  } state_e;

  state_e             state_q, state_d;
  logic [div_w-1:0]   div_q, div_d;
  logic [bit_w-1:0]   bit_q, bit_d;
  logic [width_p-1:0] frame_q, frame_d;
  logic [width_p-1:0] hold_q, hold_d;
  logic               ready_d, sclk_d, ws_d, sd_d, underflow_d;
  logic               fs;

  // Slot bit b: one-bit I2S delay, then the sample MSB first, then zero padding.
  function automatic logic slot_bit(input logic [width_p-1:0] sample,
                                    input logic [bit_w-1:0]   b);
    logic [idx_w-1:0] idx;
    slot_bit = 1'b0;
    idx      = '0;
    if ((b != '0) && (32'(b) <= width_p)) begin
      idx      = idx_w'(width_p - 32'(b));
      slot_bit = sample[idx];
    end
  endfunction

  // State register; the holding register is "full" whenever ready_o is low.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= ST_IDLE;
      div_q       <= '0;
      bit_q       <= '0;
      frame_q     <= '0;
      hold_q      <= '0;
      ready_o     <= 1'b1;
      sclk_o      <= 1'b0;
      ws_o        <= 1'b1;
      sd_o        <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      frame_q     <= frame_d;
      hold_q      <= hold_d;
      ready_o     <= ready_d;
      sclk_o      <= sclk_d;
      ws_o        <= ws_d;
      sd_o        <= sd_d;
      underflow_o <= underflow_d;
    end
  end

  // Next-state, bit clock generation, slot sequencing and handshake.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bit_d       = bit_q;
    frame_d     = frame_q;
    hold_d      = hold_q;
    ready_d     = ready_o;
    sclk_d      = sclk_o;
    ws_d        = ws_o;
    sd_d        = sd_o;
    underflow_d = 1'b0;
    fs          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        div_d  = '0;
        bit_d  = '0;
        sclk_d = 1'b0;
        ws_d   = 1'b1;
        sd_d   = 1'b0;
        if (enable_i && !ready_o) begin
          fs = 1'b1;
        end
      end
      ST_LEFT, ST_RIGHT: begin
        if (div_q == div_last) begin
          div_d  = '0;
          sclk_d = ~sclk_o;
        end else begin
          div_d = div_q + div_w'(1);
        end
        // ws/sd only move on the bit clock falling edge.
        if ((div_q == div_last) && sclk_o) begin
          if (bit_q == bit_last) begin
            bit_d = '0;
            sd_d  = 1'b0;
            if (state_q == ST_LEFT) begin
              state_d = ST_RIGHT;
              ws_d    = 1'b1;
            end else if (enable_i) begin
              fs = 1'b1;
            end else begin
              state_d = ST_IDLE;
              ws_d    = 1'b1;
            end
          end else begin
            bit_d = bit_q + bit_w'(1);
            sd_d  = slot_bit(frame_q, bit_q + bit_w'(1));
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Frame start: restart the bit clock and load the frame register.
    if (fs) begin
      state_d = ST_LEFT;
      div_d   = '0;
      bit_d   = '0;
      sclk_d  = 1'b0;
      ws_d    = 1'b0;
      sd_d    = 1'b0;
      if (!ready_o) begin
        frame_d = hold_q;
        ready_d = 1'b1;
      end else begin
        underflow_d = 1'b1;
`ifdef I2S_TX_HOLD_LAST_EN
        frame_d = frame_q;
`else
        frame_d = '0;
`endif
      end
    end

    // Accept is judged on the pre-frame-start ready, so no bypass into the frame.
    if (valid_i && ready_o) begin
      hold_d  = data_i;
      ready_d = 1'b0;
    end
  end

endmodule

// File: tb/tb_i2s_sample_tx.sv
// Bench for i2s_sample_tx: frame-timeline model compared every cycle, plus directed literal checks.
module tb_i2s_sample_tx;

  localparam int unsigned W     = 12;
  localparam int unsigned SLOT  = 16;
  localparam int unsigned DIV   = 2;
  localparam int          FRAME = 4 * DIV * SLOT;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         en    = 1'b0;
  logic         valid = 1'b0;
  logic [W-1:0] data  = '0;
  logic         ready, sclk, ws, sd, uf;

  int total = 0;
  int bad   = 0;
  int n_acc = 0;
  int n_uf  = 0;
  bit ramp  = 1'b0;

  // Model: position in the current 128-cycle frame plus holding/frame registers.
  bit           m_run       = 1'b0;
  int           m_t         = 0;
  bit           m_hold_full = 1'b0;
  logic [W-1:0] m_hold      = '0;
  logic [W-1:0] m_frame     = '0;
  bit           m_uf        = 1'b0;
  bit           m_fs, m_acc;

  logic e_sclk, e_ws, e_sd;
  int   tf, bpos;

  logic sd_tr [FRAME];
  logic ws_tr [FRAME];
  logic sclk_tr [FRAME];

  i2s_sample_tx #(
    .width_p(W),
    .slot_width_p(SLOT),
    .sclk_div_p(DIV)
  ) dut (
    .clk_i(clk),
    .reset_ni(rst_n),
    .enable_i(en),
    .valid_i(valid),
    .data_i(data),
    .ready_o(ready),
    .sclk_o(sclk),
    .ws_o(ws),
    .sd_o(sd),
    .underflow_o(uf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 1'b0; m_t = 0; m_hold_full = 1'b0; m_hold = '0; m_frame = '0; m_uf = 1'b0;
    end else begin
      m_acc = valid && !m_hold_full;
      m_fs  = m_run ? (m_t == FRAME - 1 && en) : (en && m_hold_full);
      if (m_run) begin
        if (m_t == FRAME - 1) m_run = 1'b0;
        else m_t++;
      end
      m_uf = 1'b0;
      if (m_fs) begin
        m_run = 1'b1;
        m_t   = 0;
        if (m_hold_full) begin
          m_frame     = m_hold;
          m_hold_full = 1'b0;
        end else begin
          m_uf = 1'b1;
`ifndef I2S_TX_HOLD_LAST_EN
          m_frame = '0;
`endif
        end
      end
      if (m_acc) begin
        m_hold      = data;
        m_hold_full = 1'b1;
      end
    end
  end

  // Expected outputs derived from the frame position.
  always @(negedge clk) begin
    if (m_run) begin
      tf     = m_t % (FRAME / 2);
      bpos   = tf / (2 * DIV);
      e_sclk = ((tf / DIV) % 2) == 1;
      e_ws   = (m_t >= FRAME / 2);
      e_sd   = (bpos >= 1 && bpos <= W) ? m_frame[W - bpos] : 1'b0;
    end else begin
      e_sclk = 1'b0;
      e_ws   = 1'b1;
      e_sd   = 1'b0;
    end
    check("cyc_ready", 32'(ready), 32'(!m_hold_full));
    check("cyc_sclk", 32'(sclk), 32'(e_sclk));
    check("cyc_ws", 32'(ws), 32'(e_ws));
    check("cyc_sd", 32'(sd), 32'(e_sd));
    check("cyc_uf", 32'(uf), 32'(m_uf));
    if (uf === 1'b1) n_uf++;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      logic r, v;
      r = ready;
      v = valid;
      @(posedge clk);
      #1;
      if (r && v) begin
        n_acc++;
        if (ramp) data = data + W'(1);
      end
    end
  endtask

  task automatic wait_pos(input int pos);
    int n;
    n = 0;
    while (!(m_run && m_t == pos) && n < 600) begin
      tick(1);
      n++;
    end
    check("wait_pos", 32'(m_run && m_t == pos), 32'd1);
  endtask

  initial begin
    int a0, u0, ones;

    // Reset values
    #12;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_ws", 32'(ws), 32'd1);
    check("rst_sd", 32'(sd), 32'd0);
    check("rst_uf", 32'(uf), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(2);
    en = 1'b1;
    tick(3);
    check("idle_empty_ws", 32'(ws), 32'd1);
    check("idle_empty_sclk", 32'(sclk), 32'd0);

    // 1: single 0x800 sample, frame starts the cycle after acceptance
    valid = 1'b1; data = 12'h800;
    tick(1);
    valid = 1'b0;
    check("t1_acc_ready", 32'(ready), 32'd0);
    check("t1_acc_ws", 32'(ws), 32'd1);
    tick(1);
    check("t1_fs_ready", 32'(ready), 32'd1);
    check("t1_fs_ws", 32'(ws), 32'd0);
    ramp = 1'b1; data = '0; valid = 1'b1;
    for (int k = 0; k < FRAME; k++) begin
      sd_tr[k] = sd; ws_tr[k] = ws; sclk_tr[k] = sclk;
      tick(1);
    end
    for (int b = 0; b < SLOT; b++) begin
      check("t1_left_bit", 32'(sd_tr[4 * b + 2]), (b == 1) ? 32'd1 : 32'd0);
      check("t1_right_bit", 32'(sd_tr[64 + 4 * b + 2]), (b == 1) ? 32'd1 : 32'd0);
    end
    check("t1_msb_before", 32'(sd_tr[3]), 32'd0);
    check("t1_msb_at_2div", 32'(sd_tr[4]), 32'd1);
    check("t1_sclk_lo", 32'(sclk_tr[1]), 32'd0);
    check("t1_sclk_hi", 32'(sclk_tr[2]), 32'd1);
    check("t1_ws_left_end", 32'(ws_tr[63]), 32'd0);
    check("t1_ws_right", 32'(ws_tr[64]), 32'd1);

    // 2: valid held high with a ramp, one accept per frame
    a0 = n_acc; u0 = n_uf;
    tick(4 * FRAME);
    check("t2_accepts", 32'(n_acc - a0), 32'd4);
    check("t2_no_uf", 32'(n_uf - u0), 32'd0);
    check("t2_ramp_data", 32'(data), 32'd5);

    // 3: withhold valid, next frame start underflows
    valid = 1'b0; ramp = 1'b0;
    u0 = n_uf;
    tick(FRAME);
    ones = 0;
    for (int k = 0; k < FRAME; k++) begin
      if (sd === 1'b1) ones++;
      tick(1);
    end
    check("t3_uf_once", 32'(n_uf - u0), 32'd1);
`ifdef I2S_TX_HOLD_LAST_EN
    check("t3_frame_ones", 32'(ones), 32'd8);
`else
    check("t3_frame_ones", 32'(ones), 32'd0);
`endif

    // 4: drop enable mid-left with a sample pending
    valid = 1'b1; data = 12'h123;
    tick(1);
    valid = 1'b0;
    en = 1'b0;
    begin
      int n;
      n = 0;
      while (m_run && n < 300) begin tick(1); n++; end
      check("t4_reached_idle", 32'(m_run), 32'd0);
    end
    check("t4_idle_ready", 32'(ready), 32'd0);
    check("t4_idle_ws", 32'(ws), 32'd1);
    check("t4_idle_sclk", 32'(sclk), 32'd0);
    tick(10);
    check("t4_stay_ws", 32'(ws), 32'd1);
    check("t4_stay_sclk", 32'(sclk), 32'd0);
    en = 1'b1;
    tick(1);
    check("t4_fs_ws", 32'(ws), 32'd0);
    check("t4_fs_ready", 32'(ready), 32'd1);
    check("t4_fs_uf", 32'(uf), 32'd0);

    // 6: valid in a frame-start cycle while hold is full
    wait_pos(100);
    valid = 1'b1; data = 12'h000;
    tick(1);
    valid = 1'b0;
    wait_pos(127);
    valid = 1'b1; data = 12'h800;
    a0 = n_acc;
    tick(1);
    check("t6_fs_no_accept", 32'(n_acc - a0), 32'd0);
    check("t6_fs_ready", 32'(ready), 32'd1);
    tick(1);
    check("t6_next_accept", 32'(n_acc - a0), 32'd1);
    check("t6_next_ready", 32'(ready), 32'd0);
    valid = 1'b0;
    wait_pos(4);
    check("t6_a_msb", 32'(sd), 32'd0);
    wait_pos(0);
    wait_pos(4);
    check("t6_b_msb", 32'(sd), 32'd1);

    // 5: async reset mid-slot discards the pending sample
    wait_pos(20);
    valid = 1'b1; data = 12'h7ff;
    tick(1);
    valid = 1'b0;
    wait_pos(30);
    check("t5_pre_sclk", 32'(sclk), 32'd1);
    check("t5_pre_ws", 32'(ws), 32'd0);
    check("t5_pre_ready", 32'(ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_ready", 32'(ready), 32'd1);
    check("t5_async_sclk", 32'(sclk), 32'd0);
    check("t5_async_ws", 32'(ws), 32'd1);
    check("t5_async_sd", 32'(sd), 32'd0);
    check("t5_async_uf", 32'(uf), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(20);
    check("t5_after_ws", 32'(ws), 32'd1);
    check("t5_after_sclk", 32'(sclk), 32'd0);
    check("t5_after_ready", 32'(ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
